// File: rtl/user_ctx_array.sv
// Per-user context store: lane-masked save on user end, one-cycle restore on user start,
// with valid bitmap, global clear, occupancy count and out-of-range detection.
module user_ctx_array #(
  parameter int unsigned NUM_USERS = 40,
  parameter int unsigned IDX_W     = 6,
  parameter int unsigned LANES     = 5,
  parameter int unsigned LANE_W    = 4,
  parameter int unsigned CNT_W     = 6
) (
  input  logic                      i_core_clk,
  input  logic                      i_rx_rstn,
  input  logic [LANES*LANE_W-1:0]   i_ctx_data,
  input  logic [LANES-1:0]          i_lane_we,
  input  logic [IDX_W-1:0]          i_demux_user_idx,
  input  logic                      i_demux_user_end,
  input  logic                      i_demux_user_start,
  input  logic                      i_ctx_clear_all,
  output logic [LANES*LANE_W-1:0]   o_ctx_data,
  output logic                      o_ctx_valid,
  output logic                      o_ctx_hit,
  output logic                      o_idx_err,
  output logic [CNT_W-1:0]          o_ctx_count
);

  localparam int unsigned W = LANES * LANE_W;

  logic [W-1:0]         mem [NUM_USERS];
  logic [NUM_USERS-1:0] vld;
  logic [NUM_USERS-1:0] vld_nxt;
  logic [CNT_W-1:0]     count_nxt;
  logic                 in_range;
  logic [IDX_W-1:0]     sidx;
  logic                 save;
  logic                 load;
  logic                 err_nxt;
  logic [W-1:0]         old_word;
  logic [W-1:0]         merged;
  logic [W-1:0]         rd_data;
  logic                 rd_hit;

  // Decode the strobe and build the post-save word for write and write-through.
  always_comb begin
    in_range = ({1'b0, i_demux_user_idx} < (IDX_W+1)'(NUM_USERS));
    sidx     = in_range ? i_demux_user_idx : '0;
    save     = i_demux_user_end & in_range;
    load     = i_demux_user_start & in_range;
    err_nxt  = (i_demux_user_end | i_demux_user_start) & ~in_range;
    old_word = mem[sidx];
    merged   = old_word;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (i_lane_we[k]) merged[k*LANE_W +: LANE_W] = i_ctx_data[k*LANE_W +: LANE_W];
    end
  end

  // Clear first, then save; a restore observes the resulting bitmap.
  always_comb begin
    vld_nxt = i_ctx_clear_all ? '0 : vld;
    if (save) vld_nxt[sidx] = 1'b1;
    if (i_ctx_clear_all) count_nxt = CNT_W'(save);
    else                 count_nxt = o_ctx_count + CNT_W'(save & ~vld[sidx]);
    rd_hit  = load & vld_nxt[sidx];
    rd_data = '0;
    if (rd_hit) rd_data = save ? merged : old_word;
  end

  // Context words carry no reset; a slot is only readable once its valid bit is set.
  always_ff @(posedge i_core_clk) begin
    if (save) mem[sidx] <= merged;
  end

  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      vld         <= '0;
      o_ctx_count <= '0;
      o_ctx_valid <= 1'b0;
      o_idx_err   <= 1'b0;
      o_ctx_data  <= '0;
      o_ctx_hit   <= 1'b0;
    end else begin
      vld         <= vld_nxt;
      o_ctx_count <= count_nxt;
      o_ctx_valid <= i_demux_user_start;
      o_idx_err   <= err_nxt;
      if (i_demux_user_start) begin
        o_ctx_data <= rd_data;
        o_ctx_hit  <= rd_hit;
      end
    end
  end

endmodule

// File: tb/tb_user_ctx_array.sv
// Directed plus random bench for user_ctx_array against a per-slot array reference model.
module tb_user_ctx_array;

  localparam int unsigned NU = 40;
  localparam int unsigned IW = 6;
  localparam int unsigned NL = 5;
  localparam int unsigned LW = 4;
  localparam int unsigned CW = 6;
  localparam int unsigned DW = NL * LW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] ctx_data = '0;
  logic [NL-1:0] lane_we = '0;
  logic [IW-1:0] user_idx = '0;
  logic          user_end = 1'b0;
  logic          user_start = 1'b0;
  logic          clear_all = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_hit;
  logic          idx_err;
  logic [CW-1:0] ctx_count;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [DW-1:0] m_mem [NU];
  bit            m_known [NU][NL];
  bit            m_vld [NU];
  logic [DW-1:0] e_data;
  bit            e_hit;
  bit            e_valid;
  bit            e_err;
  bit            data_known;

  user_ctx_array dut (
    .i_core_clk        (clk),
    .i_rx_rstn         (rst_n),
    .i_ctx_data        (ctx_data),
    .i_lane_we         (lane_we),
    .i_demux_user_idx  (user_idx),
    .i_demux_user_end  (user_end),
    .i_demux_user_start(user_start),
    .i_ctx_clear_all   (clear_all),
    .o_ctx_data        (out_data),
    .o_ctx_valid       (out_valid),
    .o_ctx_hit         (out_hit),
    .o_idx_err         (idx_err),
    .o_ctx_count       (ctx_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_count();
    int n = 0;
    for (int u = 0; u < int'(NU); u++) if (m_vld[u]) n++;
    return n;
  endfunction

  // One clock: drive at negedge, advance the model, compare at the next negedge.
  task automatic step(input bit st, input bit en, input bit cl, input int idx,
                      input logic [DW-1:0] d, input logic [NL-1:0] we);
    bit inr;
    user_start = st;
    user_end   = en;
    clear_all  = cl;
    user_idx   = IW'(idx);
    ctx_data   = d;
    lane_we    = we;
    inr     = (idx < int'(NU));
    e_valid = st;
    e_err   = (st || en) && !inr;
    if (cl) for (int u = 0; u < int'(NU); u++) m_vld[u] = 1'b0;
    if (en && inr) begin
      for (int k = 0; k < int'(NL); k++) begin
        if (we[k]) begin
          m_mem[idx][k*LW +: LW] = d[k*LW +: LW];
          m_known[idx][k] = 1'b1;
        end
      end
      m_vld[idx] = 1'b1;
    end
    if (st) begin
      if (inr && m_vld[idx]) begin
        e_data = m_mem[idx];
        e_hit  = 1'b1;
        data_known = 1'b1;
        for (int k = 0; k < int'(NL); k++) if (!m_known[idx][k]) data_known = 1'b0;
      end else begin
        e_data = '0;
        e_hit  = 1'b0;
        data_known = 1'b1;
      end
    end
    @(negedge clk);
    chk("valid", 32'(out_valid), 32'(e_valid));
    chk("idx_err", 32'(idx_err), 32'(e_err));
    chk("hit", 32'(out_hit), 32'(e_hit));
    chk("count", 32'(ctx_count), 32'(model_count()));
    if (data_known) chk("data", 32'(out_data), 32'(e_data));
    user_start = 1'b0;
    user_end   = 1'b0;
    clear_all  = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 0, '0, '0);
  endtask

  task automatic reset_dut(input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_data", 32'(out_data), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_hit", 32'(out_hit), 32'h0);
    chk("rst_err", 32'(idx_err), 32'h0);
    chk("rst_count", 32'(ctx_count), 32'h0);
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
    for (int u = 0; u < int'(NU); u++) m_vld[u] = 1'b0;
    e_data = '0;
    e_hit  = 1'b0;
    data_known = 1'b1;
  endtask

  initial begin
    for (int u = 0; u < int'(NU); u++) begin
      m_mem[u] = '0;
      m_vld[u] = 1'b0;
      for (int k = 0; k < int'(NL); k++) m_known[u][k] = 1'b0;
    end
    e_data = '0;
    e_hit = 1'b0;
    data_known = 1'b1;
    repeat (2) @(negedge clk);
    reset_dut(2);
    idle();

    // Basic save and later restore
    step(1'b0, 1'b1, 1'b0, 10, 20'h33333, 5'h1F);
    idle();
    step(1'b1, 1'b0, 1'b0, 10, '0, '0);
    chk("tp1_data", 32'(out_data), 32'h33333);
    chk("tp1_hit", 32'(out_hit), 32'h1);
    chk("tp1_count", 32'(ctx_count), 32'd1);
    idle();

    // Restore of an unsaved slot
    step(1'b1, 1'b0, 1'b0, 18, '0, '0);
    chk("miss_data", 32'(out_data), 32'h0);
    chk("miss_hit", 32'(out_hit), 32'h0);

    // Lane masking: lanes 0 and 2 overwritten
    step(1'b0, 1'b1, 1'b0, 39, 20'hAAAAA, 5'h1F);
    step(1'b0, 1'b1, 1'b0, 39, 20'h55555, 5'b00101);
    step(1'b1, 1'b0, 1'b0, 39, '0, '0);
    chk("mask_data", 32'(out_data), 32'hAA5A5);
    chk("mask_count", 32'(ctx_count), 32'd2);

    // Same-cycle write-through, then out-of-range strobes
    step(1'b1, 1'b1, 1'b0, 12, 20'h12345, 5'h1F);
    chk("bypass_data", 32'(out_data), 32'h12345);
    chk("bypass_hit", 32'(out_hit), 32'h1);
    step(1'b1, 1'b0, 1'b0, 45, '0, '0);
    chk("oor_err", 32'(idx_err), 32'h1);
    chk("oor_data", 32'(out_data), 32'h0);
    step(1'b1, 1'b1, 1'b0, 63, 20'hFFFFF, 5'h1F);
    idle();
    chk("oor_single", 32'(idx_err), 32'h0);
    step(1'b0, 1'b1, 1'b0, 40, 20'hFFFFF, 5'h1F);
    idle();

    // Clear with concurrent save
    step(1'b0, 1'b1, 1'b0, 1, 20'h11111, 5'h1F);
    step(1'b0, 1'b1, 1'b0, 18, 20'h18181, 5'h1F);
    step(1'b0, 1'b1, 1'b1, 1, 20'h0F0F0, 5'h1F);
    chk("clr_count", 32'(ctx_count), 32'd1);
    step(1'b1, 1'b0, 1'b0, 18, '0, '0);
    chk("clr_miss", 32'(out_hit), 32'h0);
    step(1'b1, 1'b0, 1'b0, 1, '0, '0);
    chk("clr_hit", 32'(out_hit), 32'h1);
    step(1'b1, 1'b0, 1'b1, 1, '0, '0);
    step(1'b1, 1'b1, 1'b1, 5, 20'h5A5A5, 5'h1F);
    step(1'b1, 1'b1, 1'b0, 5, 20'h00000, 5'b00010);

    // Reset mid-run discards contexts
    step(1'b0, 1'b1, 1'b0, 10, 20'h33333, 5'h1F);
    reset_dut(2);
    idle();
    step(1'b1, 1'b0, 1'b0, 10, '0, '0);
    chk("post_rst_hit", 32'(out_hit), 32'h0);
    chk("post_rst_count", 32'(ctx_count), 32'd0);

    // Randomised traffic
    for (int n = 0; n < 600; n++) begin
      if (n == 300) reset_dut(2);
      step(($urandom % 3) == 0, ($urandom % 2) == 0, ($urandom % 40) == 0,
           int'($urandom_range(0, 45)), DW'($urandom), NL'($urandom));
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
